// File: rtl/s_pe_gen.sv
// Generic processing element: operand muxing, ALU/reduction unit and a tapped delay line.
// Results are registered; the delay-line tap may be combinational at depth 0.
module s_pe_gen #(
    parameter int N_BITS    = 32,
    parameter int N_NEIGH   = 4,
    parameter int MAX_DELAY = 4,
    parameter int ACC_W     = 16,
    localparam int N_SRC    = N_NEIGH + 3,
    localparam int SEL_W    = $clog2(N_SRC),
    localparam int DEP_W    = $clog2(MAX_DELAY + 1),
    localparam int DSEL_W   = (N_NEIGH > 1) ? $clog2(N_NEIGH) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       mage_done_i,
    input  logic                       pea_ready_i,
    input  logic [SEL_W-1:0]           mux_sel_a_i,
    input  logic [SEL_W-1:0]           mux_sel_b_i,
    input  logic [2:0]                 op_i,
    input  logic [ACC_W-1:0]           acc_len_i,
    input  logic [DSEL_W-1:0]          delay_sel_i,
    input  logic [1:0]                 delay_src_i,
    input  logic [DEP_W-1:0]           delay_depth_i,
    input  logic [N_BITS-1:0]          reg_const_i,
    input  logic [N_NEIGH*N_BITS-1:0]  neigh_op_i,
    input  logic [N_NEIGH-1:0]         neigh_op_valid_i,
    input  logic [N_NEIGH*N_BITS-1:0]  neigh_delay_op_i,
    input  logic [N_NEIGH-1:0]         neigh_delay_valid_i,
    output logic [N_BITS-1:0]          pe_res_o,
    output logic                       valid_o,
    output logic                       acc_done_o,
    output logic [N_BITS-1:0]          delay_op_o,
    output logic                       delay_op_valid_o
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_ACC  = 3'd4;
    localparam logic [2:0] OP_RMAX = 3'd5;
    localparam logic [2:0] OP_MIN  = 3'd6;
    localparam logic [2:0] OP_NOP7 = 3'd7;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

    function automatic logic [N_BITS-1:0] smax(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [N_BITS-1:0] smin(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b);
        return ($signed(a) < $signed(b)) ? a : b;
    endfunction

    state_e              state_r, state_n;
    logic [ACC_W-1:0]    cnt_r, cnt_n, len_r, len_n;
    logic [N_BITS-1:0]   pe_res_r, pe_res_n;
    logic                valid_r, valid_n, acc_done_r, acc_done_n;
    logic [N_BITS-1:0]   dly_data_r [MAX_DELAY];
    logic [MAX_DELAY-1:0] dly_vld_r;

    logic [N_BITS-1:0]   src_data_s [N_SRC];
    logic [N_SRC-1:0]    src_vld_s;
    logic [N_BITS-1:0]   ndly_data_s, op_a_s, op_b_s, fu_res_s, dly_in_s;
    logic                ndly_vld_s, op_a_vld_s, op_b_vld_s, dly_in_vld_s;
    logic                is_nop_s, is_red_s, fire_s, dly_shift_s;
    logic [ACC_W-1:0]    eff_len_s, cnt_inc_s;
    logic [DEP_W-1:0]    depth_sat_s;

    // Neighbour delay-input select
    always_comb begin
        ndly_data_s = '0;
        ndly_vld_s  = 1'b0;
        for (int k = 0; k < N_NEIGH; k++) begin
            ndly_data_s = ndly_data_s | ((delay_sel_i == DSEL_W'(k)) ? neigh_delay_op_i[k*N_BITS +: N_BITS] : '0);
            ndly_vld_s  = ndly_vld_s  | ((delay_sel_i == DSEL_W'(k)) & neigh_delay_valid_i[k]);
        end
    end

    // Operand source table; unmatched selects fall through to zero/invalid
    always_comb begin
        for (int k = 0; k < N_NEIGH; k++) begin
            src_data_s[k] = neigh_op_i[k*N_BITS +: N_BITS];
            src_vld_s[k]  = neigh_op_valid_i[k];
        end
        src_data_s[N_NEIGH]   = pe_res_r;
        src_vld_s[N_NEIGH]    = 1'b1;
        src_data_s[N_NEIGH+1] = reg_const_i;
        src_vld_s[N_NEIGH+1]  = 1'b1;
        src_data_s[N_NEIGH+2] = ndly_data_s;
        src_vld_s[N_NEIGH+2]  = ndly_vld_s;
    end

    // Operand A/B multiplexers
    always_comb begin
        op_a_s     = '0;
        op_b_s     = '0;
        op_a_vld_s = 1'b0;
        op_b_vld_s = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            op_a_s     = op_a_s | ((mux_sel_a_i == SEL_W'(k)) ? src_data_s[k] : '0);
            op_b_s     = op_b_s | ((mux_sel_b_i == SEL_W'(k)) ? src_data_s[k] : '0);
            op_a_vld_s = op_a_vld_s | ((mux_sel_a_i == SEL_W'(k)) & src_vld_s[k]);
            op_b_vld_s = op_b_vld_s | ((mux_sel_b_i == SEL_W'(k)) & src_vld_s[k]);
        end
    end

    // Functional unit; reductions restart from op_b when idle
    always_comb begin
        fu_res_s = '0;
        case (op_i)
            OP_ADD:  fu_res_s = op_a_s + op_b_s;
            OP_SUB:  fu_res_s = op_a_s - op_b_s;
            OP_MUL:  fu_res_s = op_a_s * op_b_s;
            OP_MIN:  fu_res_s = smin(op_a_s, op_b_s);
            OP_ACC:  fu_res_s = (state_r == S_IDLE) ? op_b_s : (pe_res_r + op_b_s);
            OP_RMAX: fu_res_s = (state_r == S_IDLE) ? op_b_s : smax(pe_res_r, op_b_s);
            default: fu_res_s = '0;
        endcase
    end

    assign is_nop_s  = (op_i == OP_NOP) || (op_i == OP_NOP7);
    assign is_red_s  = (op_i == OP_ACC) || (op_i == OP_RMAX);
    assign fire_s    = pea_ready_i && !mage_done_i && op_a_vld_s && op_b_vld_s && !is_nop_s;
    assign eff_len_s = (acc_len_i == '0) ? ACC_W'(1) : acc_len_i;
    assign cnt_inc_s = cnt_r + ACC_W'(1);

    // Next-state logic for the result path and the reduction FSM
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        len_n      = len_r;
        pe_res_n   = pe_res_r;
        valid_n    = valid_r;
        acc_done_n = 1'b0;
        if (mage_done_i) begin
            state_n  = S_IDLE;
            cnt_n    = '0;
            len_n    = '0;
            pe_res_n = '0;
            valid_n  = 1'b0;
        end else if (is_nop_s) begin
            state_n  = S_IDLE;
            cnt_n    = '0;
            pe_res_n = '0;
            valid_n  = 1'b0;
        end else if (fire_s && is_red_s) begin
            pe_res_n = fu_res_s;
            case (state_r)
                S_IDLE: begin
                    cnt_n = ACC_W'(1);
                    len_n = eff_len_s;
                    if (eff_len_s == ACC_W'(1)) begin
                        valid_n    = 1'b1;
                        acc_done_n = 1'b1;
                        state_n    = S_IDLE;
                    end else begin
                        valid_n = 1'b0;
                        state_n = S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_n = cnt_inc_s;
                    if (cnt_inc_s == len_r) begin
                        valid_n    = 1'b1;
                        acc_done_n = 1'b1;
                        state_n    = S_IDLE;
                    end else begin
                        valid_n = 1'b0;
                        state_n = S_RUN;
                    end
                end
                default: begin
                    valid_n = 1'b0;
                    state_n = S_IDLE;
                end
            endcase
        end else if (fire_s) begin
            pe_res_n = fu_res_s;
            valid_n  = 1'b1;
        end else if (pea_ready_i) begin
            valid_n = 1'b0;
        end else begin
            valid_n = valid_r;
        end
    end

    // Result, FSM and counter registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= S_IDLE;
            cnt_r      <= '0;
            len_r      <= '0;
            pe_res_r   <= '0;
            valid_r    <= 1'b0;
            acc_done_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            len_r      <= len_n;
            pe_res_r   <= pe_res_n;
            valid_r    <= valid_n;
            acc_done_r <= acc_done_n;
        end
    end

    // Delay-line stage-0 input select
    always_comb begin
        dly_in_s     = '0;
        dly_in_vld_s = 1'b0;
        case (delay_src_i)
            2'd0: begin dly_in_s = ndly_data_s; dly_in_vld_s = ndly_vld_s; end
            2'd1: begin dly_in_s = op_a_s;      dly_in_vld_s = op_a_vld_s; end
            2'd2: begin dly_in_s = op_b_s;      dly_in_vld_s = op_b_vld_s; end
            2'd3: begin dly_in_s = fu_res_s;    dly_in_vld_s = fire_s;     end
            default: begin dly_in_s = '0;       dly_in_vld_s = 1'b0;       end
        endcase
    end

    assign dly_shift_s = pea_ready_i && !mage_done_i;

    // Delay-line shift register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < MAX_DELAY; k++) dly_data_r[k] <= '0;
            dly_vld_r <= '0;
        end else if (mage_done_i) begin
            for (int k = 0; k < MAX_DELAY; k++) dly_data_r[k] <= '0;
            dly_vld_r <= '0;
        end else if (dly_shift_s) begin
            dly_data_r[0] <= dly_in_s;
            dly_vld_r[0]  <= dly_in_vld_s;
            for (int k = 1; k < MAX_DELAY; k++) begin
                dly_data_r[k] <= dly_data_r[k-1];
                dly_vld_r[k]  <= dly_vld_r[k-1];
            end
        end else begin
            dly_vld_r <= dly_vld_r;
        end
    end

    assign depth_sat_s = (delay_depth_i > DEP_W'(MAX_DELAY)) ? DEP_W'(MAX_DELAY) : delay_depth_i;

    // Delay-line tap; depth 0 bypasses the stages
    always_comb begin
        delay_op_o       = (depth_sat_s == '0) ? dly_in_s : '0;
        delay_op_valid_o = (depth_sat_s == '0) & dly_in_vld_s;
        for (int k = 0; k < MAX_DELAY; k++) begin
            delay_op_o       = delay_op_o | ((depth_sat_s == DEP_W'(k+1)) ? dly_data_r[k] : '0);
            delay_op_valid_o = delay_op_valid_o | ((depth_sat_s == DEP_W'(k+1)) & dly_vld_r[k]);
        end
    end

    assign pe_res_o   = pe_res_r;
    assign valid_o    = valid_r;
    assign acc_done_o = acc_done_r;

endmodule

// File: tb/tb_s_pe_gen.sv
// Scoreboard bench for s_pe_gen: stimulus queues expected results, a negedge monitor checks them.
module tb_s_pe_gen;

    logic         clk_i = 1'b0;
    logic         rst_n_i, mage_done_i, pea_ready_i;
    logic [2:0]   mux_sel_a_i, mux_sel_b_i, op_i, delay_depth_i;
    logic [15:0]  acc_len_i;
    logic [1:0]   delay_sel_i, delay_src_i;
    logic [31:0]  reg_const_i;
    logic [127:0] neigh_op_i, neigh_delay_op_i;
    logic [3:0]   neigh_op_valid_i, neigh_delay_valid_i;
    logic [31:0]  pe_res_o, delay_op_o;
    logic         valid_o, acc_done_o, delay_op_valid_o;

    typedef struct { logic [31:0] res; logic done; } exp_t;
    exp_t exp_q[$];
    int n_total = 0;
    int n_pass  = 0;

    s_pe_gen dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .mage_done_i(mage_done_i), .pea_ready_i(pea_ready_i),
        .mux_sel_a_i(mux_sel_a_i), .mux_sel_b_i(mux_sel_b_i), .op_i(op_i), .acc_len_i(acc_len_i),
        .delay_sel_i(delay_sel_i), .delay_src_i(delay_src_i), .delay_depth_i(delay_depth_i),
        .reg_const_i(reg_const_i), .neigh_op_i(neigh_op_i), .neigh_op_valid_i(neigh_op_valid_i),
        .neigh_delay_op_i(neigh_delay_op_i), .neigh_delay_valid_i(neigh_delay_valid_i),
        .pe_res_o(pe_res_o), .valid_o(valid_o), .acc_done_o(acc_done_o),
        .delay_op_o(delay_op_o), .delay_op_valid_o(delay_op_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_res(input logic [31:0] r, input logic d);
        exp_t e;
        e.res  = r;
        e.done = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every valid result must match the head of the scoreboard
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1) begin
            if (valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_valid: got pe_res %h, required no output", pe_res_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", pe_res_o, e.res);
                    chk("acc_done", 32'(acc_done_o), 32'(e.done));
                end
            end else if (acc_done_o === 1'b1) begin
                n_total++;
                $display("FAIL stray_acc_done: got acc_done 1 with valid 0, required 0");
            end
        end
    end

    initial begin
        rst_n_i = 1'b0; mage_done_i = 1'b0; pea_ready_i = 1'b0;
        mux_sel_a_i = 3'd0; mux_sel_b_i = 3'd5; op_i = 3'd0; acc_len_i = 16'd0;
        delay_sel_i = 2'd0; delay_src_i = 2'd1; delay_depth_i = 3'd1; reg_const_i = 32'd0;
        neigh_op_i = 128'd0; neigh_op_valid_i = 4'b0001;
        neigh_delay_op_i = 128'd0; neigh_delay_valid_i = 4'b0000;
        cyc(); cyc();
        chk("rst_pe_res", pe_res_o, 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_acc_done", 32'(acc_done_o), 32'd0);
        chk("rst_dly_valid", 32'(delay_op_valid_o), 32'd0);
        rst_n_i = 1'b1;
        pea_ready_i = 1'b1;

        // ADD / SUB / MUL / MIN back to back
        op_i = 3'd1; neigh_op_i[31:0] = 32'd5; reg_const_i = 32'd7;
        expect_res(32'd12, 1'b0); cyc();
        op_i = 3'd2; expect_res(32'hFFFF_FFFE, 1'b0); cyc();
        op_i = 3'd3; neigh_op_i[31:0] = 32'h0001_0001; reg_const_i = 32'h0001_0001;
        expect_res(32'h0002_0001, 1'b0); cyc();
        op_i = 3'd6; neigh_op_i[31:0] = 32'hFFFF_FFFD; reg_const_i = 32'd2;
        expect_res(32'hFFFF_FFFD, 1'b0); cyc();
        mux_sel_a_i = 3'd7; cyc();
        chk("nofire_valid", 32'(valid_o), 32'd0);
        chk("nofire_hold", pe_res_o, 32'hFFFF_FFFD);
        op_i = 3'd0; cyc();
        chk("nop_clear", pe_res_o, 32'd0);

        // ACC of 1,2,3,4
        mux_sel_a_i = 3'd5; op_i = 3'd4; acc_len_i = 16'd4;
        reg_const_i = 32'd1; cyc();
        reg_const_i = 32'd2; cyc();
        reg_const_i = 32'd3; cyc();
        chk("acc_partial_valid", 32'(valid_o), 32'd0);
        chk("acc_partial_sum", pe_res_o, 32'd6);
        reg_const_i = 32'd4; expect_res(32'd10, 1'b1); cyc();
        op_i = 3'd0; cyc();
        chk("acc_done_pulse", 32'(acc_done_o), 32'd0);

        // RMAX of -5,9,2 with a two-cycle stall; acc_len change mid-run must be ignored
        op_i = 3'd5; acc_len_i = 16'd3;
        reg_const_i = 32'hFFFF_FFFB; cyc();
        reg_const_i = 32'd9; cyc();
        pea_ready_i = 1'b0; reg_const_i = 32'd100; acc_len_i = 16'd1;
        cyc(); cyc();
        chk("stall_hold", pe_res_o, 32'd9);
        chk("stall_valid", 32'(valid_o), 32'd0);
        pea_ready_i = 1'b1; reg_const_i = 32'd2; expect_res(32'd9, 1'b1); cyc();
        op_i = 3'd0; cyc();

        // Zero length behaves as length 1
        op_i = 3'd4; acc_len_i = 16'd0; reg_const_i = 32'h20;
        expect_res(32'h20, 1'b1); cyc();
        op_i = 3'd0; cyc();

        // mage_done mid-reduction, then a fresh sum
        op_i = 3'd4; acc_len_i = 16'd4;
        reg_const_i = 32'd1; cyc();
        reg_const_i = 32'd2; cyc();
        mage_done_i = 1'b1; cyc();
        chk("mage_pe_res", pe_res_o, 32'd0);
        chk("mage_valid", 32'(valid_o), 32'd0);
        chk("mage_done_flag", 32'(acc_done_o), 32'd0);
        mage_done_i = 1'b0;
        expect_res(32'd26, 1'b1);
        for (int i = 5; i <= 8; i++) begin reg_const_i = 32'(i); cyc(); end
        op_i = 3'd0; cyc();

        // Async reset mid-reduction, then a fresh sum
        op_i = 3'd4;
        reg_const_i = 32'd1; cyc();
        reg_const_i = 32'd2; cyc();
        chk("pre_reset_sum", pe_res_o, 32'd3);
        rst_n_i = 1'b0; #2;
        chk("async_rst_pe_res", pe_res_o, 32'd0);
        chk("async_rst_valid", 32'(valid_o), 32'd0);
        cyc(); rst_n_i = 1'b1;
        expect_res(32'd4, 1'b1);
        reg_const_i = 32'd1;
        for (int i = 0; i < 4; i++) cyc();
        op_i = 3'd0; cyc();

        // Delay line fed from op_a (constant), NOP throughout
        delay_src_i = 2'd1; mux_sel_a_i = 3'd5;
        reg_const_i = 32'hA; cyc();
        reg_const_i = 32'hB; cyc();
        reg_const_i = 32'hC; cyc();
        reg_const_i = 32'hD;
        delay_depth_i = 3'd3; #1; chk("dly_d3", delay_op_o, 32'hA);
        chk("dly_d3_valid", 32'(delay_op_valid_o), 32'd1);
        delay_depth_i = 3'd0; #1; chk("dly_d0", delay_op_o, 32'hD);
        delay_depth_i = 3'd2; #1; chk("dly_d2", delay_op_o, 32'hB);
        cyc();
        delay_depth_i = 3'd7; #1; chk("dly_d7_sat", delay_op_o, 32'hA);
        delay_depth_i = 3'd1; #1; chk("dly_d1", delay_op_o, 32'hD);
        pea_ready_i = 1'b0; reg_const_i = 32'hE; cyc();
        chk("dly_stall", delay_op_o, 32'hD);
        pea_ready_i = 1'b1;
        delay_depth_i = 3'd0; delay_src_i = 2'd2; #1; chk("dly_src_opb", delay_op_o, 32'hE);
        delay_src_i = 2'd0; delay_sel_i = 2'd2; neigh_delay_op_i[95:64] = 32'h55;
        neigh_delay_valid_i = 4'b0100; #1;
        chk("dly_src_neigh", delay_op_o, 32'h55);
        chk("dly_src_neigh_v", 32'(delay_op_valid_o), 32'd1);
        neigh_delay_valid_i = 4'b0000; #1;
        chk("dly_neigh_inval", 32'(delay_op_valid_o), 32'd0);
        delay_src_i = 2'd3; #1; chk("dly_fu_nofire", 32'(delay_op_valid_o), 32'd0);
        delay_src_i = 2'd1; mux_sel_a_i = 3'd7; #1;
        chk("dly_sel_oob", delay_op_o, 32'd0);
        mux_sel_a_i = 3'd5;
        mage_done_i = 1'b1; cyc(); mage_done_i = 1'b0;
        delay_depth_i = 3'd1; #1;
        chk("dly_mage_clear", delay_op_o, 32'd0);
        chk("dly_mage_clear_v", 32'(delay_op_valid_o), 32'd0);

        cyc(); cyc(); cyc();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/s_pe_gen.md
S_PE_GEN -- requirements
Module: s_pe_gen

Interface
REQ-001 Parameter N_BITS, default 32: datapath width.
REQ-002 Parameter N_NEIGH, default 4: number of neighbour PE operand and delay inputs.
REQ-003 Parameter MAX_DELAY, default 4: delay-line depth.
REQ-004 Parameter ACC_W, default 16: accumulation-length counter width.
REQ-005 Localparam N_SRC = N_NEIGH+3; SEL_W = $clog2(N_SRC); DEP_W = $clog2(MAX_DELAY+1).
REQ-006 Clock and reset SHALL be: one clock; reset is asynchronous and active-low (clk_i, rst_n_i).
REQ-007 clk_i  in  1  clock.
REQ-008 rst_n_i  in  1  async active-low reset.
REQ-009 mage_done_i  in  1  kernel finished, synchronous clear.
REQ-010 pea_ready_i  in  1  array-wide advance enable.
REQ-011 mux_sel_a_i, mux_sel_b_i  in  SEL_W each  operand selects.
REQ-012 op_i  in  3  opcode: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 ACC, 5 RMAX, 6 MIN, 7 NOP.
REQ-013 acc_len_i  in  ACC_W  reduction length.
REQ-014 delay_sel_i  in  $clog2(N_NEIGH)  neighbour delay-input select.
REQ-015 delay_src_i  in  2  delay-line source: 0 neighbour delay, 1 op_a, 2 op_b, 3 FU result.
REQ-016 delay_depth_i  in  DEP_W  delay-line tap.
REQ-017 reg_const_i  in  N_BITS  constant operand.
REQ-018 neigh_op_i / neigh_op_valid_i  in  N_NEIGH x N_BITS / N_NEIGH  neighbour results.
REQ-019 neigh_delay_op_i / neigh_delay_valid_i  in  N_NEIGH x N_BITS / N_NEIGH  neighbour delay outputs.
REQ-020 pe_res_o  out  N_BITS  registered result; valid_o  out  1  result valid.
REQ-021 acc_done_o  out  1  one-cycle pulse at reduction completion.
REQ-022 delay_op_o / delay_op_valid_o  out  N_BITS / 1  delay-line output.

Function
REQ-023 Operand index: 0..N_NEIGH-1 neighbours, N_NEIGH self (pe_res_o, always valid), N_NEIGH+1 reg_const_i (always valid), N_NEIGH+2 selected neighbour delay input; indices >= N_SRC read as zero and invalid.
REQ-024 fire = pea_ready_i && !mage_done_i && op_a valid && op_b valid && op_i not NOP.
REQ-025 Arithmetic: two's complement, result truncated to N_BITS; MUL keeps low N_BITS; MIN/RMAX signed compare.
REQ-026 ADD/SUB/MUL/MIN: on fire, pe_res_o <= result and valid_o <= 1 (latency 1); pea_ready_i high without fire -> valid_o <= 0, pe_res_o held; pea_ready_i low -> both held.
REQ-027 ACC/RMAX use FSM IDLE/RUN, counter cnt (ACC_W), op_a ignored, op_b streamed.
REQ-028 IDLE + fire: pe_res_o <= op_b, cnt <= 1; if effective length is 1, valid_o <= 1 and acc_done_o pulses, stay IDLE; else go RUN, valid_o <= 0.
REQ-029 RUN + fire: pe_res_o <= pe_res_o+op_b (ACC) or signed max (RMAX), cnt++; when cnt+1 == length, valid_o <= 1, acc_done_o <= 1, go IDLE; otherwise valid_o <= 0.
REQ-030 acc_len_i == 0 SHALL be treated as length 1; acc_len_i is sampled only in IDLE.
REQ-031 acc_done_o is registered and high for exactly one cycle; valid_o in ACC/RMAX drops to 0 on the next fire-or-ready cycle.
REQ-032 op_i NOP: next edge pe_res_o <= 0, valid_o <= 0, FSM <= IDLE, cnt <= 0; the delay line is unaffected.
REQ-033 Delay line: MAX_DELAY stages of {valid, data}, shifting when pea_ready_i && !mage_done_i; stage-0 input selected by delay_src_i with its matching valid (FU result valid = fire).
REQ-034 delay_depth_i == 0: outputs equal the stage-0 input combinationally; d in 1..MAX_DELAY: stage d; d > MAX_DELAY saturates to MAX_DELAY.
REQ-035 mage_done_i high: next edge clears pe_res_o, valid_o, acc_done_o, FSM, cnt and all delay stages, overriding all else.

Reset
REQ-036 rst_n_i low asynchronously clears pe_res_o, valid_o, acc_done_o, cnt, all delay stages and their valids; FSM = IDLE.
REQ-037 Reset mid-reduction discards the partial sum; no acc_done_o is produced.

Verification
REQ-038 ADD, a=neigh0=5, b=const=7, all valid, ready -> pe_res_o=12, valid_o=1 one cycle later.
REQ-039 ACC, acc_len=4, op_b stream 1,2,3,4 one per cycle -> valid_o and acc_done_o high only after the 4th, pe_res_o=10.
REQ-040 RMAX, acc_len=3, stream -5,9,2, with pea_ready_i low for 2 cycles mid-stream -> result 9, counter and sum held during the stall.
REQ-041 delay_src=1, depth=3, op_a=0xA,0xB,0xC... -> delay_op_o shows 0xA exactly 3 ready cycles later; depth=0 -> same cycle; depth=7 with MAX_DELAY=4 -> 4 cycles.
REQ-042 acc_len=0 with one input 0x20 -> immediate valid_o and acc_done_o, pe_res_o=0x20.
REQ-043 Reset or mage_done_i after 2 of 4 ACC inputs -> all outputs 0; the next 4 inputs produce a fresh sum.
